// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {carry,sum} = a + b + c, one bit per cycle, LSB first, done_out WIDTH+1 cycles after start.
// No backpressure: start_in is taken only in IDLE or DONE; results are held until the next completion.

module full_adder_2h (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic s_out,
    output logic c_out
);
    logic h1_s;
    logic h1_c;
    logic h2_c;

    // Two cascaded half adders; either half producing a carry sets c_out.
    assign h1_s  = a_in ^ b_in;
    assign h1_c  = a_in & b_in;
    assign s_out = h1_s ^ c_in;
    assign h2_c  = h1_s & c_in;
    assign c_out = h1_c | h2_c;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_shift;
    logic             unused_res_lsb;

    full_adder_2h u_fa (
        .a_in  (a_q[0]),
        .b_in  (b_q[0]),
        .c_in  (cy_q),
        .s_out (fa_s),
        .c_out (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = fa_s;
        end else begin : g_res_wn
            assign res_shift = {fa_s, res_q[WIDTH-1:1]};
        end
    endgenerate

    assign unused_res_lsb = res_q[0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cy_d    = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cy_d  = fa_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    carry_d = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy_out  = (state_q == RUN);
    assign done_out  = (state_q == DONE);
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH 8, 13 and 1 against a timing/arithmetic model.
module tb_serial_adder_ctrl;
    localparam int NDUT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        st [NDUT];
    logic [31:0] av [NDUT];
    logic [31:0] bv [NDUT];
    logic        cv [NDUT];
    logic        busy_v  [NDUT];
    logic        done_v  [NDUT];
    logic        carry_v [NDUT];
    logic [31:0] sum_v   [NDUT];

    logic [7:0]  a8, b8, sum8;
    logic [12:0] a13, b13, sum13;
    logic [0:0]  a1, b1, sum1;

    assign a8  = 8'(av[0]);
    assign b8  = 8'(bv[0]);
    assign a13 = 13'(av[1]);
    assign b13 = 13'(bv[1]);
    assign a1  = 1'(av[2]);
    assign b1  = 1'(bv[2]);
    assign sum_v[0] = 32'(sum8);
    assign sum_v[1] = 32'(sum13);
    assign sum_v[2] = 32'(sum1);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(st[0]), .a_in(a8), .b_in(b8), .c_in(cv[0]),
        .busy_out(busy_v[0]), .done_out(done_v[0]), .sum_out(sum8), .carry_out(carry_v[0]));
    serial_adder_ctrl #(.WIDTH(13)) dut13 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(st[1]), .a_in(a13), .b_in(b13), .c_in(cv[1]),
        .busy_out(busy_v[1]), .done_out(done_v[1]), .sum_out(sum13), .carry_out(carry_v[1]));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(st[2]), .a_in(a1), .b_in(b1), .c_in(cv[2]),
        .busy_out(busy_v[2]), .done_out(done_v[2]), .sum_out(sum1), .carry_out(carry_v[2]));

    int errs = 0;
    int nchk = 0;
    bit checking = 1'b0;

    // Model: an accept at edge N means RUN after edges N..N+W-1, DONE after N+W.
    int          cyc = 0;
    int          acc     [NDUT];
    bit          acc_vld [NDUT];
    logic [63:0] pend    [NDUT];
    logic [63:0] held    [NDUT];
    int          nacc    [NDUT];

    function automatic int wid(int d);
        return (d == 0) ? 8 : (d == 1) ? 13 : 1;
    endfunction

    function automatic logic [63:0] msk(int d);
        return (64'd1 << wid(d)) - 64'd1;
    endfunction

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s w=%0d t=%0t actual=%0h required=%0h", nm, wid(d), $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                acc[d] = 0; acc_vld[d] = 1'b0; pend[d] = '0; held[d] = '0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < NDUT; d++) begin
                int prevk;
                if (acc_vld[d] && (cyc - acc[d] == wid(d)))
                    held[d] = pend[d];
                prevk = cyc - 1 - acc[d];
                if (!(acc_vld[d] && prevk >= 0 && prevk <= wid(d) - 1) && st[d]) begin
                    acc[d]     = cyc;
                    acc_vld[d] = 1'b1;
                    pend[d]    = (64'(av[d]) & msk(d)) + (64'(bv[d]) & msk(d)) + 64'(cv[d]);
                    nacc[d]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < NDUT; d++) begin
                int k;
                bit eb, ed;
                k  = cyc - acc[d];
                eb = acc_vld[d] && k >= 0 && k <= wid(d) - 1;
                ed = acc_vld[d] && k == wid(d);
                chk("busy",  d, 64'(busy_v[d]),  64'(eb));
                chk("done",  d, 64'(done_v[d]),  64'(ed));
                chk("sum",   d, 64'(sum_v[d]),   held[d] & msk(d));
                chk("carry", d, 64'(carry_v[d]), (held[d] >> wid(d)) & 64'd1);
            end
        end
    end

    task automatic op(int d, logic [31:0] a, logic [31:0] b, logic c,
                      output int n, output int nb, output logic [31:0] mid_sum, output logic mid_c);
        @(negedge clk);
        st[d] = 1'b1; av[d] = a; bv[d] = b; cv[d] = c;
        n = 0; nb = 0; mid_sum = '0; mid_c = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                st[d] = 1'b0; av[d] = $urandom; bv[d] = $urandom; cv[d] = 1'($urandom_range(0, 1));
            end
            if (n == 4) begin
                mid_sum = sum_v[d]; mid_c = carry_v[d];
            end
            if (busy_v[d]) nb++;
        end while (!done_v[d] && n < 60);
        chk("done_seen", d, 64'(done_v[d]), 64'd1);
    endtask

    task automatic rnd(int d, int nops);
        int target, guard;
        target = nacc[d] + nops;
        guard  = 0;
        while (nacc[d] < target && guard < 60000) begin
            @(negedge clk);
            st[d] = ($urandom_range(0, 2) == 0);
            av[d] = $urandom; bv[d] = $urandom; cv[d] = 1'($urandom_range(0, 1));
            guard++;
        end
        chk("rnd_ops_done", d, 64'(nacc[d] >= target), 64'd1);
        @(negedge clk);
        st[d] = 1'b0;
        repeat (wid(d) + 4) @(negedge clk);
    endtask

    initial begin
        int n, nb, cnt;
        logic [31:0] ms;
        logic mc;
        for (int d = 0; d < NDUT; d++) begin
            st[d] = 1'b0; av[d] = '0; bv[d] = '0; cv[d] = 1'b0; nacc[d] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_busy",  d, 64'(busy_v[d]),  64'd0);
            chk("rst_done",  d, 64'(done_v[d]),  64'd0);
            chk("rst_sum",   d, 64'(sum_v[d]),   64'd0);
            chk("rst_carry", d, 64'(carry_v[d]), 64'd0);
        end
        rst_n = 1'b1;

        op(0, 32'hFF, 32'h01, 1'b0, n, nb, ms, mc);
        chk("ff01_latency", 0, 64'(n), 64'd9);
        chk("ff01_busy_cycles", 0, 64'(nb), 64'd8);
        chk("ff01_sum", 0, 64'(sum_v[0]), 64'h00);
        chk("ff01_carry", 0, 64'(carry_v[0]), 64'd1);

        op(0, 32'h5A, 32'h3C, 1'b1, n, nb, ms, mc);
        chk("5a3c_held_sum", 0, 64'(ms), 64'h00);
        chk("5a3c_held_carry", 0, 64'(mc), 64'd1);
        chk("5a3c_sum", 0, 64'(sum_v[0]), 64'h97);
        chk("5a3c_carry", 0, 64'(carry_v[0]), 64'd0);

        op(1, 32'h1FFF, 32'h1, 1'b0, n, nb, ms, mc);
        chk("w13_latency", 1, 64'(n), 64'd14);
        chk("w13_sum", 1, 64'(sum_v[1]), 64'h0);
        chk("w13_carry", 1, 64'(carry_v[1]), 64'd1);

        op(2, 32'h1, 32'h1, 1'b1, n, nb, ms, mc);
        chk("w1_latency", 2, 64'(n), 64'd2);
        chk("w1_sum", 2, 64'(sum_v[2]), 64'h1);
        chk("w1_carry", 2, 64'(carry_v[2]), 64'd1);

        // Start held high with operands changing every cycle.
        @(negedge clk);
        st[0] = 1'b1; av[0] = $urandom; bv[0] = $urandom; cv[0] = 1'($urandom_range(0, 1));
        cnt = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (done_v[0]) cnt++;
            st[0] = (i != 26); av[0] = $urandom; bv[0] = $urandom; cv[0] = 1'($urandom_range(0, 1));
        end
        chk("b2b_done_pulses", 0, 64'(cnt), 64'd3);
        repeat (3) @(negedge clk);

        // Reset in the middle of a RUN.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'h12; bv[0] = 32'h34; cv[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",  0, 64'(busy_v[0]),  64'd0);
        chk("midrst_done",  0, 64'(done_v[0]),  64'd0);
        chk("midrst_sum",   0, 64'(sum_v[0]),   64'd0);
        chk("midrst_carry", 0, 64'(carry_v[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) cnt++;
        end
        chk("midrst_no_done", 0, 64'(cnt), 64'd0);
        op(0, 32'h12, 32'h34, 1'b0, n, nb, ms, mc);
        chk("post_rst_latency", 0, 64'(n), 64'd9);
        chk("post_rst_sum", 0, 64'(sum_v[0]), 64'h46);
        chk("post_rst_carry", 0, 64'(carry_v[0]), 64'd0);

        fork
            rnd(0, 1000);
            rnd(1, 1000);
            rnd(2, 200);
        join

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
